// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared op codes, FSM states and sizing helpers for alu_exec_unit
package alu_exec_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Width of the multiply iteration counter for a given operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/alu_iter_mul.sv
// rtl/alu_iter_mul.sv - iterative radix-2 shift-add multiplier, WIDTH steps per product
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      load operands and begin iterating (ignored while busy)
//   a_i, b_i     multiplicand, multiplier (sampled on start_i)
//   done_o       high during the cycle whose rising edge performs the last step
//   product_o    accumulator value after the step taken at the next edge;
//                holds the final low-WIDTH product while done_o is high
module alu_iter_mul
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] step_acc;

  // Accumulator after this cycle's conditional add; exported so the caller
  // can capture the final product on the same edge as the last step.
  assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (count_q == LAST);
  assign product_o = step_acc;

  always_comb begin
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (count_q == LAST) begin
        busy_d = 1'b0;
      end
    end else if (start_i) begin
      busy_d   = 1'b1;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshakes and iterative MUL
//
// Optional feature macro: ALU_OVF_EN (adds registered signed-overflow flag ovf).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand bundle handshake (alu_control, src_a, src_b)
//   out_valid / out_ready  result handshake (result, zero, illegal_op[, ovf])
//   result                 registered result
//   zero                   registered result==0 flag
//   illegal_op             registered, result came from an illegal op code
//   ovf                    (ALU_OVF_EN only) registered signed overflow of ADD/SUB
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
`ifdef ALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] sum, diff;

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;
`ifdef ALU_OVF_EN
  assign ovf        = ovf_q;
`endif

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  alu_iter_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .a_i      (src_a),
    .b_i      (src_b),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_comb begin
    state_d     = state_q;
    // A consumed result clears out_valid unless a new write lands on the same edge.
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
`ifdef ALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    mul_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_control == ALU_MUL) begin
            mul_start   = 1'b1;
            state_d     = MUL;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            illegal_d   = 1'b0;
`ifdef ALU_OVF_EN
            ovf_d       = 1'b0;
`endif
            case (alu_control)
              ALU_AND: result_d = src_a & src_b;
              ALU_OR:  result_d = src_a | src_b;
              ALU_ADD: begin
                result_d = sum;
`ifdef ALU_OVF_EN
                ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
`endif
              end
              ALU_SUB: begin
                result_d = diff;
`ifdef ALU_OVF_EN
                ovf_d = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
`endif
              end
              ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
              default: begin
                result_d  = '0;
                illegal_d = 1'b1;
              end
            endcase
            zero_d = (result_d == '0);
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          illegal_d   = 1'b0;
`ifdef ALU_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit (directed + random vs reference model)
module tb_alu_exec_unit;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_control = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal_op;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
`ifdef ALU_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on wide signed/unsigned integers.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output logic ov);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ill = 1'b0;
    ov = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin s = sa + sb; r = W'(s); ov = (s > SMAX) || (s < SMIN); end
      3'd4: begin s = sa - sb; r = W'(s); ov = (s > SMAX) || (s < SMIN); end
      3'd5: begin p = {32'd0, a} * {32'd0, b}; r = p[W-1:0]; end
      3'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      default: begin r = '0; ill = 1'b1; end
    endcase
  endfunction

  // Issue one op with out_ready=1 and check latency and all result fields.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic ill, ov;
    int n, ready_hi;
    model(op, a, b, r, ill, ov);
    out_ready = 1'b1;
    in_valid = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: the unit must have sampled them at accept only.
    alu_control = 3'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    n = 0;
    ready_hi = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) ready_hi++;
      @(posedge clk); #1; n++;
    end
    check("latency", n, (op == 3'd5) ? W : 0);
    if (op == 3'd5) check("mul_in_ready_low", ready_hi, 0);
    check("out_valid", out_valid, 1);
    check("result", result, r);
    check("zero", zero, (r == '0));
    check("illegal_op", illegal_op, ill);
`ifdef ALU_OVF_EN
    check("ovf", ovf, ov);
`endif
    @(posedge clk); #1;
    check("consumed", out_valid, 0);
  endtask

  initial begin
    int stale;
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd3, 3'd7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Back-to-back single-cycle ops: ADD 5+7, SUB 3-3, SLT -1<1
    in_valid = 1'b1; alu_control = 3'd2; src_a = 32'd5; src_b = 32'd7;
    @(posedge clk); #1;
    check("add_valid", out_valid, 1);
    check("add_result", result, 12);
    check("add_zero", zero, 0);
    check("b2b_in_ready", in_ready, 1);
    alu_control = 3'd4; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    check("sub_result", result, 0);
    check("sub_zero", zero, 1);
    check("sub_valid", out_valid, 1);
    alu_control = 3'd6; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
    @(posedge clk); #1;
    check("slt_result", result, 1);
    check("slt_zero", zero, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_drained", out_valid, 0);

    // Multiply
    run_op(3'd5, 32'd7, 32'd6);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd5, 32'd0, 32'h1234_5678);

    // Backpressure: ADD held while OR waits, then consume + accept on one edge
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'd2; src_a = 32'd1; src_b = 32'd2;
    @(posedge clk); #1;
    alu_control = 3'd1; src_a = 32'h0000_00F0; src_b = 32'h0000_000F;
    check("bp_first_result", result, 3);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("bp_held_result", result, 3);
      check("bp_held_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_or_result", result, 32'hFF);
    check("bp_or_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Illegal codes, then a legal op clears the flag
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1);
    run_op(3'd0, 32'hF0F0_F0F0, 32'hFFFF_0000);
    run_op(3'd3, 32'd9, 32'd9);
    run_op(3'd2, 32'h7FFF_FFFF, 32'd1);
    run_op(3'd4, 32'h8000_0000, 32'd1);

    // Reset during MUL iteration 10: aborted, nothing emitted afterwards
    in_valid = 1'b1; alu_control = 3'd5; src_a = 32'd11; src_b = 32'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("no_stale_result", stale, 0);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 15));
      run_op(ops[$urandom_range(0, 7)], a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit alu_control code produced by the ALU decoder and returns a registered result.
- Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in 1 cycle; MUL runs an iterative radix-2 shift-add over WIDTH cycles.
- Valid/ready handshake on both the operand side and the result side.
- Sits between the control/decode path and the writeback mux; used by the multicycle variant of the core.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- alu_control  input  3  op code: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT; 011/111 illegal.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered flag, result==0.
- illegal_op  output  1  registered; result was produced from an illegal code.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0; all multiply registers cleared. Reset mid-MUL aborts the operation; nothing is emitted.
- States: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; independent of in_valid.
- Accept = in_valid && in_ready at a rising edge.
- Result consumed = out_valid && out_ready at the edge. Consumption and a new accept in the same edge are legal; the new write wins and out_valid stays 1.
- Single-cycle op, accept at edge k:
  - result, zero and illegal_op are written at edge k; out_valid=1 after k (latency 1).
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is signed two's complement: result = {WIDTH-1 zeros, (a<b)}.
  - Illegal code: result=0, zero=1, illegal_op=1.
- MUL, accept at edge k:
  - Load multiplicand=src_a, multiplier=src_b, acc=0, count=0; state to MUL.
  - Edges k+1..k+WIDTH: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++.
  - At edge k+WIDTH: result = final acc (low WIDTH bits of the unsigned product; equals the signed low half); zero updated; illegal_op=0; out_valid=1; state to IDLE.
  - in_ready=0 throughout MUL.
- A MUL accept consumes the slot (out_valid=0 after k unless a prior result is still pending, which in_ready excludes).
- out_valid, result, zero and illegal_op hold stable until consumed. With out_ready held low, the unit stalls indefinitely and in_ready=0.
- alu_control and operand inputs are sampled only at accept; later changes are ignored.

Optional Feature:
- ALU_OVF_EN:
  - Defined: adds output port ovf (1 bit, registered, reset 0). Set to 1 on signed overflow of ADD/SUB; 0 for all other ops, including MUL.
  - Undefined: ovf port absent; no overflow logic.

Decomposition:
- Package alu_exec_pkg holds:
  - alu_control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT);
  - the state enum (IDLE, MUL);
  - the width of the count field, $clog2(WIDTH+1).
- One natural sub-module: alu_iter_mul, containing the shift-add datapath with start/done signals. The FSM, handshake and single-cycle ops stay in the top level.

Test Plan:
- Reset then ADD 5+7, out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0; in_ready stays 1 (back-to-back ops every cycle).
- SUB 3-3, then SLT 0xFFFFFFFF vs 1 -> result 0 with zero=1; then result 1 (signed -1<1).
- MUL 7*6 (WIDTH=32) -> in_ready=0 for 32 cycles; out_valid rises 32 edges after the accept edge; result=42. Also MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- Backpressure: out_ready=0, issue ADD, then assert in_valid with OR -> in_ready=0, first result held unchanged. Raise out_ready -> consume and OR accept on the same edge.
- Illegal code 3'b111 -> result=0, zero=1, illegal_op=1. The next legal op clears illegal_op.
- rst_n low at MUL iteration 10 -> out_valid=0 immediately (async), state IDLE; after release, in_ready=1 and no stale result appears. With ALU_OVF_EN: ADD 0x7FFFFFFF+1 -> ovf=1.
